// File: rtl/mcpu_ctrl_pkg.sv
// ============================================================================
// Module      : mcpu_ctrl_pkg
// Description : Shared widths and run-state encoding for the run controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mcpu_ctrl_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 6;
  localparam int MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } run_state_t;

endpackage

`default_nettype wire

// File: rtl/mcpu_ctrl_mem.sv
// ============================================================================
// Module      : mcpu_ctrl_mem
// Description : 16x6 program/data array, one sync write port, two comb reads.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcpu_ctrl_mem
  import mcpu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_cpu_raddr,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic [ADDR_W-1:0] i_host_raddr,
  output logic [DATA_W-1:0] o_host_rdata
);

  // Contents survive reset so a program can be rerun without reloading.
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_cpu_rdata  = r_mem[i_cpu_raddr];
  assign o_host_rdata = r_mem[i_host_raddr];

endmodule

`default_nettype wire

// File: rtl/mcpu_run_controller.sv
// ============================================================================
// Module      : mcpu_run_controller
// Description : LOAD/RUN/DONE sequencer and memory owner for the 6-bit CPU.
//               Optional watchdog enabled by defining MCPU_WATCHDOG_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mcpu_run_controller
  import mcpu_ctrl_pkg::*;
#(
  parameter int              CNT_W      = 8,
  parameter logic [ADDR_W-1:0] HALT_ADDR = 4'hF,
  parameter int              MAX_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_start,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we_n,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [1:0]        run_state,
  output logic [DATA_W-1:0] result,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

`ifdef MCPU_WATCHDOG_EN
  localparam logic c_WDOG_EN = 1'b1;
`else
  localparam logic c_WDOG_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_t        r_state;
  logic              r_cpu_rst_n;
  logic [DATA_W-1:0] r_result;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_host_we;
  logic              w_cpu_we;
  logic              w_halt;
  logic              w_wdog_hit;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [CNT_W-1:0]  w_cnt_next;

  assign host_ready = (r_state != ST_RUN);
  assign w_host_we  = host_valid & host_ready;
  assign w_cpu_we   = (r_state == ST_RUN) & r_cpu_rst_n & ~cpu_we_n;
  assign w_halt     = w_cpu_we & (cpu_addr == HALT_ADDR);
  assign w_wdog_hit = c_WDOG_EN & (r_cnt == c_WDOG_LAST);
  assign w_cnt_next = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  // Host and CPU never own the port in the same state, so a plain mux suffices.
  assign w_mem_we   = w_host_we | w_cpu_we;
  assign w_mem_addr = w_cpu_we ? cpu_addr  : host_addr;
  assign w_mem_data = w_cpu_we ? cpu_wdata : host_wdata;

  mcpu_ctrl_mem u_mem (
    .clk          (clk),
    .i_we         (w_mem_we),
    .i_waddr      (w_mem_addr),
    .i_wdata      (w_mem_data),
    .i_cpu_raddr  (cpu_addr),
    .o_cpu_rdata  (cpu_rdata),
    .i_host_raddr (host_addr),
    .o_host_rdata (host_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_LOAD;
      r_cpu_rst_n <= 1'b0;
      r_result    <= '0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (host_start) begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state     <= ST_DONE;
            r_cpu_rst_n <= 1'b0;
            r_result    <= cpu_wdata;
            r_cnt       <= w_cnt_next;
          end else if (w_wdog_hit) begin
            // Counter freezes on the expiry cycle so it reads MAX_CYCLES-1.
            r_state     <= ST_DONE;
            r_cpu_rst_n <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt       <= w_cnt_next;
          end
        end
        ST_DONE: begin
          if (host_start) begin
            r_state     <= ST_RUN;
            r_cpu_rst_n <= 1'b1;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
          end else if (host_valid) begin
            r_state     <= ST_LOAD;
          end
        end
        default: begin
          r_state     <= ST_LOAD;
          r_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rst_n = r_cpu_rst_n;
  assign run_state = r_state;
  assign result    = r_result;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_run_controller.sv
// ============================================================================
// Module      : tb_mcpu_run_controller
// Description : Randomized bench with a behavioural model of the run controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mcpu_run_controller;

  localparam int TB_CNT_W = 8;
  localparam int TB_MAX   = 10;
  localparam int SAT      = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] host_addr;
  logic [5:0] host_wdata;
  logic [5:0] host_rdata;
  logic       host_start;
  logic       cpu_rst_n;
  logic [3:0] cpu_addr;
  logic [5:0] cpu_wdata;
  logic       cpu_we_n;
  logic [5:0] cpu_rdata;
  logic [1:0] run_state;
  logic [5:0] result;
  logic       timeout;
  logic [TB_CNT_W-1:0] cycle_cnt;

  always #5 clk = ~clk;

  mcpu_run_controller #(
    .CNT_W      (TB_CNT_W),
    .HALT_ADDR  (4'hF),
    .MAX_CYCLES (TB_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_start (host_start),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we_n   (cpu_we_n),
    .cpu_rdata  (cpu_rdata),
    .run_state  (run_state),
    .result     (result),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt)
  );

  // Reference model: mode 0=LOAD 1=RUN 2=DONE
  logic [5:0] m_mem   [16];
  bit         m_known [16];
  int         m_mode = 0;
  int         m_cnt  = 0;
  int         m_res  = 0;
  int         m_to   = 0;
  bit         m_live = 1'b0;
`ifdef MCPU_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_edge();
    bit halt;
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_res = 0; m_to = 0;
      return;
    end
    if (host_valid && m_mode != 1) begin
      m_mem[host_addr] = host_wdata; m_known[host_addr] = 1'b1;
    end
    halt = 1'b0;
    if (m_mode == 1 && !cpu_we_n) begin
      m_mem[cpu_addr] = cpu_wdata; m_known[cpu_addr] = 1'b1;
      halt = (cpu_addr == 4'hF);
    end
    case (m_mode)
      0: if (host_start) begin m_mode = 1; m_cnt = 0; m_to = 0; end
      1: begin
        if (halt) begin
          m_mode = 2; m_res = cpu_wdata; m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
        end else if (WDOG && m_cnt == TB_MAX - 1) begin
          m_mode = 2; m_to = 1;
        end else begin
          m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
        end
      end
      default: begin
        if (host_start) begin m_mode = 1; m_cnt = 0; m_to = 0; end
        else if (host_valid) m_mode = 0;
      end
    endcase
  endfunction

  task automatic step();
    #1;
    // Just before the edge: host_start must not reach cpu_rst_n combinationally
    if (m_live) begin
      check_val("pre_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, m_mode == 1});
      check_val("pre_host_ready", {31'd0, host_ready}, {31'd0, m_mode != 1});
    end
    model_edge();
    @(posedge clk);
    #1;
    m_live = 1'b1;
    check_val("run_state", 32'(run_state), 32'(m_mode));
    check_val("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, m_mode == 1});
    check_val("host_ready", {31'd0, host_ready}, {31'd0, m_mode != 1});
    check_val("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    check_val("result", 32'(result), 32'(m_res));
    check_val("timeout", 32'(timeout), 32'(m_to));
    if (m_known[host_addr]) check_val("host_rdata", 32'(host_rdata), 32'(m_mem[host_addr]));
    if (m_known[cpu_addr])  check_val("cpu_rdata", 32'(cpu_rdata), 32'(m_mem[cpu_addr]));
  endtask

  task automatic idle_inputs();
    host_valid = 1'b0; host_start = 1'b0; cpu_we_n = 1'b1;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [5:0] d);
    host_valid = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_valid = 1'b0;
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [5:0] d);
    cpu_we_n = 1'b0; cpu_addr = a; cpu_wdata = d;
    step();
    cpu_we_n = 1'b1;
  endtask

  task automatic start_run();
    host_start = 1'b1;
    step();
    host_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
    rst = 1'b0; host_addr = 4'h0; host_wdata = 6'h0; cpu_addr = 4'h0; cpu_wdata = 6'h0;
    idle_inputs();
    step(); step();
    rst = 1'b1;

    // Fill memory, then three known words with readback
    for (int i = 0; i < 16; i++) host_wr(4'(i), 6'($urandom));
    host_wr(4'h1, 6'h11); host_wr(4'h2, 6'h22); host_wr(4'h3, 6'h33);
    for (int i = 1; i < 4; i++) begin host_addr = 4'(i); step(); end

    // Start with a simultaneous host write, then let it count
    host_valid = 1'b1; host_addr = 4'h0; host_wdata = 6'h3C;
    start_run();
    host_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // CPU write during RUN; concurrent host write to the same address ignored
    host_valid = 1'b1; host_addr = 4'h5; host_wdata = 6'h01;
    cpu_wr(4'h5, 6'h2A);
    host_valid = 1'b0;
    step();

    // Halt store
    cpu_wr(4'hF, 6'h15);
    host_addr = 4'hF; step();

    // Rerun from DONE with a write presented alongside start
    host_valid = 1'b1; host_addr = 4'h7; host_wdata = 6'h2F;
    start_run();
    host_valid = 1'b0;
    step(); step();
    cpu_wr(4'hF, 6'h3E);
    host_wr(4'h8, 6'h08);          // DONE -> LOAD with commit
    step();

    // Long run: saturation (or watchdog expiry when enabled)
    start_run();
    for (int i = 0; i < 300; i++) step();
    cpu_wr(4'hF, 6'h2B);
    step();

    // Watchdog boundary: halt on the last permitted cycle
    host_start = 1'b1; step(); host_start = 1'b0;
    for (int i = 0; i < TB_MAX - 1; i++) step();
    cpu_wr(4'hF, 6'h19);
    step();

    // Reset in the middle of a run
    start_run();
    step(); step();
    rst = 1'b0; step(); rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin host_addr = 4'(i); step(); end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(99) >= 2);
      host_start = ($urandom_range(9) == 0);
      host_valid = rst && ($urandom_range(1) == 0);
      host_addr  = 4'($urandom);
      host_wdata = 6'($urandom);
      cpu_we_n   = !rst || ($urandom_range(3) != 0);
      cpu_addr   = 4'($urandom);
      cpu_wdata  = 6'($urandom);
      step();
    end

    idle_inputs();
    rst = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
